inst_dispatch_queue: RTL and testbench

Instruction buffer and issue sequencer between the program counter and the systolic-array core. It accepts instructions from the program counter into a small FIFO and acknowledges each one, so fetch runs ahead of execution. It issues one instruction at a time to the array, only when the array reports idle, and waits for the array's completion flag before issuing the next. NOP instructions are retired locally; HALT freezes issue until software resumes.

---
 rtl/inst_dispatch_queue_pkg.sv | 18 +
 rtl/inst_dispatch_queue_if.sv | 28 ++
 rtl/inst_dispatch_queue_fifo.sv | 55 +++++
 rtl/inst_dispatch_queue.sv | 122 ++++++++++++
 tb/tb_inst_dispatch_queue.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_dispatch_queue_pkg.sv
// Shared constants and FSM state type for the instruction dispatch queue.
package inst_dispatch_queue_pkg;

  localparam int unsigned INST_BITS   = 128;
  localparam int unsigned OPCODE_BITS = 4;
  localparam int unsigned OPCODE_TO   = 0;
  localparam int unsigned OPCODE_FROM = OPCODE_TO + OPCODE_BITS - 1;

  localparam logic [OPCODE_BITS-1:0] OPCODE_NOP  = 4'h0;
  localparam logic [OPCODE_BITS-1:0] OPCODE_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_HALT      = 2'd2
  } state_t;

endpackage

// File: rtl/inst_dispatch_queue_if.sv
// Program-counter and systolic-array handshake bundle for inst_dispatch_queue.
interface inst_dispatch_queue_if
  import inst_dispatch_queue_pkg::*;
#(
  parameter int unsigned INST_BITS = inst_dispatch_queue_pkg::INST_BITS
);

  logic [INST_BITS-1:0] pc_instruction;
  logic                 pc_init_inst_pulse;
  logic                 pc_flag;
  logic                 q_full;
  logic                 q_empty;
  logic [INST_BITS-1:0] sa_instruction;
  logic                 sa_init_inst_pulse;
  logic                 sa_idle_flag;
  logic                 sa_flag;

  modport slave (
    input  pc_instruction, pc_init_inst_pulse, sa_idle_flag, sa_flag,
    output pc_flag, q_full, q_empty, sa_instruction, sa_init_inst_pulse
  );

  modport master (
    output pc_instruction, pc_init_inst_pulse, sa_idle_flag, sa_flag,
    input  pc_flag, q_full, q_empty, sa_instruction, sa_init_inst_pulse
  );

endinterface

// File: rtl/inst_dispatch_queue_fifo.sv
// inst_fifo: synchronous FIFO, extra-MSB pointers, registered head-of-queue read data.
module inst_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_next;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    rd_next = rd_ptr;
    if (do_pop) rd_next = rd_ptr + PTR_ONE;
  end

  // rd_data is prefetched from the slot rd_next points at; a word written into
  // that same slot this edge is forwarded so the head is valid one cycle after push.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= rd_next;
      if (do_push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) rd_data <= wr_data;
      else                                                 rd_data <= mem[rd_next[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/inst_dispatch_queue.sv
// Instruction buffer and issue sequencer between the program counter and the systolic array.
// Optional performance counters are built when INST_PERF_CNT_EN is defined.
module inst_dispatch_queue
  import inst_dispatch_queue_pkg::*;
#(
  parameter int unsigned INST_BITS = inst_dispatch_queue_pkg::INST_BITS,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic                resume,
  inst_dispatch_queue_if.slave bus,
  output logic                halted,
  output logic                busy,
  output logic [CNT_BITS-1:0] retired_cnt,
  output logic [31:0]         busy_cycles,
  output logic [31:0]         stall_cycles
);

  state_t                 state;
  state_t                 state_nxt;
  logic [INST_BITS-1:0]   head;
  logic [OPCODE_BITS-1:0] head_op;
  logic                   full;
  logic                   empty;
  logic                   pop;
  logic                   issue;
  logic                   retire;

  inst_fifo #(
    .WIDTH (INST_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (bus.pc_init_inst_pulse),
    .pop     (pop),
    .wr_data (bus.pc_instruction),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign head_op     = head[OPCODE_FROM:OPCODE_TO];
  assign bus.q_full  = full;
  assign bus.q_empty = empty;
  assign halted      = (state == S_HALT);
  assign busy        = (state == S_WAIT_DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    issue     = 1'b0;
    retire    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && run && bus.sa_idle_flag) begin
          pop = 1'b1;
          if (head_op == OPCODE_NOP) begin
            retire = 1'b1;
          end else if (head_op == OPCODE_HALT) begin
            state_nxt = S_HALT;
          end else begin
            issue     = 1'b1;
            state_nxt = S_WAIT_DONE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (bus.sa_flag) begin
          retire    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_HALT: begin
        if (resume) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.pc_flag            <= 1'b0;
      bus.sa_init_inst_pulse <= 1'b0;
      bus.sa_instruction     <= '0;
      retired_cnt            <= '0;
    end else begin
      bus.pc_flag            <= bus.pc_init_inst_pulse && !full;
      bus.sa_init_inst_pulse <= issue;
      if (issue)  bus.sa_instruction <= head;
      if (retire) retired_cnt <= retired_cnt + CNT_BITS'(1);
    end
  end

`ifdef INST_PERF_CNT_EN
  logic stall;

  assign stall = (state == S_IDLE) && !empty && run && !bus.sa_idle_flag;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_cycles  <= '0;
      stall_cycles <= '0;
    end else begin
      if (busy && (busy_cycles != '1))   busy_cycles  <= busy_cycles + 32'd1;
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign busy_cycles  = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_inst_dispatch_queue.sv
// Self-checking bench for inst_dispatch_queue: cycle table, corner-case sequences, random vs queue model.
module tb_inst_dispatch_queue;
  import inst_dispatch_queue_pkg::*;

  localparam int unsigned W        = 128;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned CNT_BITS = 16;
`ifdef INST_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset_n;
  logic                run;
  logic                resume;
  logic                halted;
  logic                busy;
  logic [CNT_BITS-1:0] retired_cnt;
  logic [31:0]         busy_cycles;
  logic [31:0]         stall_cycles;

  inst_dispatch_queue_if #(.INST_BITS(W)) bus ();

  inst_dispatch_queue #(
    .INST_BITS (W),
    .DEPTH     (DEPTH),
    .CNT_BITS  (CNT_BITS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .resume       (resume),
    .bus          (bus),
    .halted       (halted),
    .busy         (busy),
    .retired_cnt  (retired_cnt),
    .busy_cycles  (busy_cycles),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst_n, run, push, idle, flag, res;
    logic [3:0]  op;
    logic        pcf, iss, emp, ful, bsy, hlt;
    logic [15:0] ret;
    logic [31:0] stl;
    int          tag;
  } vec_t;

  vec_t v[22];

  function automatic vec_t mkv(input logic rst_n, r, p, id, f, rs, input logic [3:0] op,
                               input logic pcf, iss, emp, ful, bsy, hlt,
                               input int ret, stl, tag);
    vec_t t;
    t.rst_n = rst_n; t.run = r; t.push = p; t.idle = id; t.flag = f; t.res = rs; t.op = op;
    t.pcf = pcf; t.iss = iss; t.emp = emp; t.ful = ful; t.bsy = bsy; t.hlt = hlt;
    t.ret = 16'(ret); t.stl = PERF ? 32'(stl) : 32'd0; t.tag = tag;
    return t;
  endfunction

  function automatic logic [127:0] mk_word(input int tag, input logic [3:0] op);
    return {64'hC0DE_0000_5A5A_0000, 28'h0, 32'(tag), op};
  endfunction

  function automatic logic [3:0] op_w(input int k);
    return 4'(1 + (k % 14));
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, r, p, input logic [127:0] w, input logic id, f, rs);
    reset_n                = rst;
    run                    = r;
    bus.pc_init_inst_pulse = p;
    bus.pc_instruction     = w;
    bus.sa_idle_flag       = id;
    bus.sa_flag            = f;
    resume                 = rs;
  endtask

  task automatic reset_seq();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int acks;
    int n;
    bit full_seen;

    // Cycle table: single issue, ignored sa_flag, NOP/HALT/resume, array-busy stall.
    //           rst run psh idl flg res op     pcf iss emp ful bsy hlt ret stl tag
    v[0]  = mkv(0, 0, 0, 0, 0, 0, 4'h0,  0, 0, 1, 0, 0, 0, 0, 0, -1);
    v[1]  = mkv(1, 1, 1, 1, 0, 0, 4'h1,  1, 0, 0, 0, 0, 0, 0, 0, -1);
    v[2]  = mkv(1, 1, 0, 1, 0, 0, 4'h0,  0, 1, 1, 0, 1, 0, 0, 0,  1);
    v[3]  = mkv(1, 1, 0, 1, 0, 0, 4'h0,  0, 0, 1, 0, 1, 0, 0, 0, -1);
    v[4]  = mkv(1, 1, 0, 1, 1, 0, 4'h0,  0, 0, 1, 0, 0, 0, 1, 0, -1);
    v[5]  = mkv(1, 1, 0, 1, 1, 0, 4'h0,  0, 0, 1, 0, 0, 0, 1, 0, -1);
    v[6]  = mkv(1, 1, 1, 1, 0, 0, 4'h0,  1, 0, 0, 0, 0, 0, 1, 0, -1);
    v[7]  = mkv(1, 1, 1, 1, 0, 0, 4'hF,  1, 0, 0, 0, 0, 0, 2, 0, -1);
    v[8]  = mkv(1, 1, 1, 1, 0, 0, 4'h2,  1, 0, 0, 0, 0, 1, 2, 0, -1);
    v[9]  = mkv(1, 1, 0, 1, 0, 0, 4'h0,  0, 0, 0, 0, 0, 1, 2, 0, -1);
    v[10] = mkv(1, 1, 0, 1, 0, 0, 4'h0,  0, 0, 0, 0, 0, 1, 2, 0, -1);
    v[11] = mkv(1, 1, 0, 1, 0, 1, 4'h0,  0, 0, 0, 0, 0, 0, 2, 0, -1);
    v[12] = mkv(1, 1, 0, 1, 0, 0, 4'h0,  0, 1, 1, 0, 1, 0, 2, 0,  8);
    v[13] = mkv(1, 1, 0, 1, 1, 0, 4'h0,  0, 0, 1, 0, 0, 0, 3, 0, -1);
    v[14] = mkv(1, 1, 1, 0, 0, 0, 4'h3,  1, 0, 0, 0, 0, 0, 3, 0, -1);
    for (int k = 0; k < 5; k++)
      v[15+k] = mkv(1, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 3, k + 1, -1);
    v[20] = mkv(1, 1, 0, 1, 0, 0, 4'h0,  0, 1, 1, 0, 1, 0, 3, 5, 14);
    v[21] = mkv(1, 1, 0, 1, 1, 0, 4'h0,  0, 0, 1, 0, 0, 0, 4, 5, -1);

    for (int i = 0; i < 22; i++) begin
      drive(v[i].rst_n, v[i].run, v[i].push, v[i].push ? mk_word(i, v[i].op) : 128'h0,
            v[i].idle, v[i].flag, v[i].res);
      tick();
      check($sformatf("v%0d pc_flag", i), bus.pc_flag, v[i].pcf);
      check($sformatf("v%0d issue", i), bus.sa_init_inst_pulse, v[i].iss);
      check($sformatf("v%0d q_empty", i), bus.q_empty, v[i].emp);
      check($sformatf("v%0d q_full", i), bus.q_full, v[i].ful);
      check($sformatf("v%0d busy", i), busy, v[i].bsy);
      check($sformatf("v%0d halted", i), halted, v[i].hlt);
      check($sformatf("v%0d retired_cnt", i), retired_cnt, v[i].ret);
      check($sformatf("v%0d stall_cycles", i), stall_cycles, v[i].stl);
      if (i == 0) check("v0 sa_instruction", bus.sa_instruction, 128'h0);
      if (v[i].tag >= 0)
        check($sformatf("v%0d sa_instruction", i), bus.sa_instruction,
              mk_word(v[i].tag, v[v[i].tag].op));
    end

    // Fill with run low: 9 pushes, 8 accepted, then drain in FIFO order.
    reset_seq();
    acks = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 1'b1, mk_word(100 + i, op_w(i)), 1'b1, 1'b0, 1'b0);
      tick();
      acks += int'(bus.pc_flag);
    end
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("fill ack count", 128'(acks), 128'd8);
    check("fill q_full", bus.q_full, 1'b1);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (!bus.sa_init_inst_pulse && n < 10) begin
        tick();
        n++;
      end
      check($sformatf("fill issue %0d seen", i), bus.sa_init_inst_pulse, 1'b1);
      check($sformatf("fill issue %0d word", i), bus.sa_instruction, mk_word(100 + i, op_w(i)));
      drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    tick();
    tick();
    check("fill drained q_empty", bus.q_empty, 1'b1);
    check("fill retired_cnt", retired_cnt, 16'd8);

    // Reset while an instruction is outstanding and three entries are queued.
    reset_seq();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, mk_word(300 + i, 4'h5), 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("rst pre busy", busy, 1'b1);
    check("rst pre q_empty", bus.q_empty, 1'b0);
    drive(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    check("rst q_empty", bus.q_empty, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst retired_cnt", retired_cnt, 16'd0);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    check("rst late sa_flag retired_cnt", retired_cnt, 16'd0);
    check("rst late sa_flag issue", bus.sa_init_inst_pulse, 1'b0);

    // Pointer wrap: every pop edge also carries a push.
    reset_seq();
    full_seen = 1'b0;
    drive(1'b1, 1'b1, 1'b1, mk_word(200, op_w(0)), 1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 20; k++) begin
      if (k < 19) drive(1'b1, 1'b1, 1'b1, mk_word(201 + k, op_w(k + 1)), 1'b1, 1'b0, 1'b0);
      else        drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      full_seen |= bus.q_full;
      check($sformatf("wrap %0d issue", k), bus.sa_init_inst_pulse, 1'b1);
      check($sformatf("wrap %0d word", k), bus.sa_instruction, mk_word(200 + k, op_w(k)));
      check($sformatf("wrap %0d q_empty", k), bus.q_empty, (k < 19) ? 1'b0 : 1'b1);
      drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      tick();
      full_seen |= bus.q_full;
    end
    check("wrap retired_cnt", retired_cnt, 16'd20);
    check("wrap q_full never", full_seen, 1'b0);

    // Random stimulus against a queue-level reference model.
    reset_seq();
    begin
      logic [127:0] mq[$];
      bit           m_out, m_halt;
      int unsigned  m_ret;
      logic [31:0]  m_busy, m_stall;
      logic [127:0] m_sa, w;
      m_out = 0; m_halt = 0; m_ret = 0; m_busy = '0; m_stall = '0; m_sa = '0;
      for (int c = 0; c < 600; c++) begin
        bit do_rst, p, r, id, f, rs, exp_pcf, exp_iss, was_empty, was_full;
        int unsigned k;
        logic [3:0] op;
        logic [127:0] word;
        do_rst = ($urandom_range(0, 199) == 0);
        p      = ($urandom_range(0, 99) < 45);
        r      = ($urandom_range(0, 9) < 8);
        id     = ($urandom_range(0, 9) < 7);
        f      = ($urandom_range(0, 3) == 0);
        rs     = ($urandom_range(0, 4) == 0);
        k      = $urandom_range(0, 9);
        op     = (k == 0) ? OPCODE_NOP : (k == 1) ? OPCODE_HALT : 4'($urandom_range(1, 14));
        word   = {$urandom, $urandom, $urandom, $urandom};
        word[3:0] = op;
        drive(!do_rst, r, p, word, id, f, rs);
        tick();

        exp_pcf = 0;
        exp_iss = 0;
        if (do_rst) begin
          mq.delete();
          m_out = 0; m_halt = 0; m_ret = 0; m_busy = '0; m_stall = '0; m_sa = '0;
        end else begin
          was_empty = (mq.size() == 0);
          was_full  = (mq.size() == DEPTH);
          if (m_out && m_busy != '1) m_busy++;
          if (!m_halt && !m_out && !was_empty && r && !id && m_stall != '1) m_stall++;
          exp_pcf = p && !was_full;
          if (m_halt) begin
            if (rs) m_halt = 0;
          end else if (m_out) begin
            if (f) begin
              m_out = 0;
              m_ret++;
            end
          end else if (!was_empty && r && id) begin
            w = mq.pop_front();
            if (w[3:0] == OPCODE_NOP) m_ret++;
            else if (w[3:0] == OPCODE_HALT) m_halt = 1;
            else begin
              m_sa    = w;
              exp_iss = 1;
              m_out   = 1;
            end
          end
          if (exp_pcf) mq.push_back(word);
        end

        check($sformatf("rnd%0d pc_flag", c), bus.pc_flag, exp_pcf);
        check($sformatf("rnd%0d issue", c), bus.sa_init_inst_pulse, exp_iss);
        check($sformatf("rnd%0d sa_instruction", c), bus.sa_instruction, m_sa);
        check($sformatf("rnd%0d q_empty", c), bus.q_empty, mq.size() == 0);
        check($sformatf("rnd%0d q_full", c), bus.q_full, mq.size() == DEPTH);
        check($sformatf("rnd%0d halted", c), halted, m_halt);
        check($sformatf("rnd%0d busy", c), busy, m_out);
        check($sformatf("rnd%0d retired_cnt", c), retired_cnt, 16'(m_ret));
        check($sformatf("rnd%0d busy_cycles", c), busy_cycles, PERF ? m_busy : 32'd0);
        check($sformatf("rnd%0d stall_cycles", c), stall_cycles, PERF ? m_stall : 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
